// File: rtl/gf2_tc3_mul_serial.sv
// gf2_tc3_mul_serial: three-way split digit-serial GF(2)[x] multiplier with start/done handshake.
// Define TC3_OUT_PIPE_EN to add a register stage between recombination and c (latency M+2).
module gf2_tc3_mul_serial #(
   parameter int N     = 571,
   parameter int DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-2:0] c
);
   localparam int S  = (N + 2) / 3;
   localparam int M  = (S + DIGIT - 1) / DIGIT;
   localparam int W  = 2 * S - 1;
   localparam int AW = 3 * S;
   localparam int CW = 6 * S - 1;
   localparam int CN = 2 * N - 1;
   localparam int NW = $clog2(M + 1);
   typedef enum logic [1:0] {IDLE, MUL, COMB, PIPE} state_t;
`ifdef TC3_OUT_PIPE_EN
   localparam state_t LAST = PIPE;
`else
   localparam state_t LAST = COMB;
`endif
   state_t state, state_nx;
   logic [NW-1:0] cnt;
   logic [AW-1:0] ar, br;
   logic [W-1:0] acc [3][3];
   logic [W-1:0] acc_nx [3][3];
   logic [DIGIT-1:0] ash [3];
   logic [CN-1:0] comb_v;
   int base;
   assign busy = state != IDLE;
   assign base = int'(cnt) * DIGIT;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? MUL : IDLE;
         MUL:     state_nx = (cnt == NW'(M - 1)) ? COMB : MUL;
`ifdef TC3_OUT_PIPE_EN
         COMB:    state_nx = PIPE;
         PIPE:    state_nx = IDLE;
`else
         COMB:    state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
   end
   // Limbs are zero-padded to S bits, so bits past a limb's width or past S never contribute.
   always_comb begin
      acc_nx = acc;
      for (int p = 0; p < 3; p++) begin
         ash[p] = DIGIT'(ar[p*S +: S] >> base);
         for (int q = 0; q < 3; q++)
            for (int j = 0; j < DIGIT; j++)
               if (ash[p][j]) acc_nx[p][q] = acc_nx[p][q] ^ (W'(br[q*S +: S]) << (base + j));
      end
   end
   assign comb_v = CN'(CW'(acc[0][0])
                 ^ (CW'(acc[0][1] ^ acc[1][0]) << S)
                 ^ (CW'(acc[0][2] ^ acc[1][1] ^ acc[2][0]) << (2 * S))
                 ^ (CW'(acc[1][2] ^ acc[2][1]) << (3 * S))
                 ^ (CW'(acc[2][2]) << (4 * S)));
`ifdef TC3_OUT_PIPE_EN
   logic [CN-1:0] cp;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         ar   <= '0;
         br   <= '0;
         cnt  <= '0;
         done <= 1'b0;
         c    <= '0;
         for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3; q++) acc[p][q] <= '0;
`ifdef TC3_OUT_PIPE_EN
         cp   <= '0;
`endif
      end else begin
         done <= state == LAST;
         if (state == IDLE && start) begin
            ar  <= AW'(a);
            br  <= AW'(b);
            cnt <= '0;
            for (int p = 0; p < 3; p++)
               for (int q = 0; q < 3; q++) acc[p][q] <= '0;
         end
         if (state == MUL) begin
            cnt <= cnt + NW'(1);
            acc <= acc_nx;
         end
`ifdef TC3_OUT_PIPE_EN
         if (state == COMB) cp <= comb_v;
         if (state == PIPE) c <= cp;
`else
         if (state == COMB) c <= comb_v;
`endif
      end
   end
endmodule
